// File: rtl/image_reader_pipe.sv
// Pipelined frame-buffer reader: screen coordinates to BRAM address with
// 1x/2x scale, mirror and flip; RGB565 unpack with syncs kept in step.
module image_reader_pipe #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int MEM_LAT = 1,
    parameter int COLOR_W = 4,
    parameter logic [3*COLOR_W-1:0] BORDER_RGB = '0,
    localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               DE,
    input  logic               h_sync,
    input  logic               v_sync,
    input  logic [9:0]         x_pixel,
    input  logic [9:0]         y_pixel,
    input  logic               scale_2x,
    input  logic               mirror_en,
    input  logic               flip_en,
    output logic [ADDR_W-1:0]  addr,
    output logic               rd_en,
    input  logic [15:0]        imgData,
    output logic [COLOR_W-1:0] r_port,
    output logic [COLOR_W-1:0] g_port,
    output logic [COLOR_W-1:0] b_port,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out
);

    localparam int SUM_W = (ADDR_W + 2 > 20) ? ADDR_W + 2 : 20;
    localparam logic [SUM_W-1:0] W_L  = SUM_W'(IMG_W);
    localparam logic [SUM_W-1:0] H_L  = SUM_W'(IMG_H);
    localparam logic [SUM_W-1:0] W_M1 = SUM_W'(IMG_W - 1);
    localparam logic [SUM_W-1:0] H_M1 = SUM_W'(IMG_H - 1);

    // Frame-shadowed configuration
    logic scale_q, scale_d;
    logic mirror_q, mirror_d;
    logic flip_q, flip_d;

    // Stage A
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        sx, sy;
    logic [SUM_W-1:0]  sx_w, sy_w, col_w, row_w, lin_w;
    logic              in_win;

    // Delay lines: index 0 is the stage-A register, index MEM_LAT meets imgData
    logic [MEM_LAT:0] win_q, win_d;
    logic [MEM_LAT:0] de_q, de_d;
    logic [MEM_LAT:0] hs_q, hs_d;
    logic [MEM_LAT:0] vs_q, vs_d;

    // Stage C
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
    logic               de_o_q, de_o_d;
    logic               hs_o_q, hs_o_d;
    logic               vs_o_q, vs_o_d;

    logic unused_data;
    assign unused_data = ^imgData;

    // vs_q[0] is the registered v_sync used for falling-edge detection
    always_comb begin
        scale_d  = scale_q;
        mirror_d = mirror_q;
        flip_d   = flip_q;
        if (vs_q[0] && !v_sync) begin
            scale_d  = scale_2x;
            mirror_d = mirror_en;
            flip_d   = flip_en;
        end
    end

    always_comb begin
        sx     = scale_q ? {1'b0, x_pixel[9:1]} : x_pixel;
        sy     = scale_q ? {1'b0, y_pixel[9:1]} : y_pixel;
        sx_w   = SUM_W'(sx);
        sy_w   = SUM_W'(sy);
        in_win = DE && (sx_w < W_L) && (sy_w < H_L);
        col_w  = mirror_q ? (W_M1 - sx_w) : sx_w;
        row_w  = flip_q ? (H_M1 - sy_w) : sy_w;
        lin_w  = row_w * W_L + col_w;
        addr_d = in_win ? ADDR_W'(lin_w) : addr_q;
    end

    always_comb begin
        win_d = {win_q[MEM_LAT-1:0], in_win};
        de_d  = {de_q[MEM_LAT-1:0], DE};
        hs_d  = {hs_q[MEM_LAT-1:0], h_sync};
        vs_d  = {vs_q[MEM_LAT-1:0], v_sync};
    end

    always_comb begin
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        de_o_d = de_q[MEM_LAT];
        hs_o_d = hs_q[MEM_LAT];
        vs_o_d = vs_q[MEM_LAT];
        if (de_q[MEM_LAT] && win_q[MEM_LAT]) begin
            r_d = imgData[15 -: COLOR_W];
            g_d = imgData[10 -: COLOR_W];
            b_d = imgData[4 -: COLOR_W];
        end else if (de_q[MEM_LAT]) begin
            {r_d, g_d, b_d} = BORDER_RGB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scale_q  <= 1'b1;
            mirror_q <= 1'b1;
            flip_q   <= 1'b0;
            addr_q   <= '0;
            win_q    <= '0;
            de_q     <= '0;
            hs_q     <= '1;
            vs_q     <= '1;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            de_o_q   <= 1'b0;
            hs_o_q   <= 1'b1;
            vs_o_q   <= 1'b1;
        end else begin
            scale_q  <= scale_d;
            mirror_q <= mirror_d;
            flip_q   <= flip_d;
            addr_q   <= addr_d;
            win_q    <= win_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            de_o_q   <= de_o_d;
            hs_o_q   <= hs_o_d;
            vs_o_q   <= vs_o_d;
        end
    end

    assign addr       = addr_q;
    assign rd_en      = win_q[0];
    assign r_port     = r_q;
    assign g_port     = g_q;
    assign b_port     = b_q;
    assign de_out     = de_o_q;
    assign h_sync_out = hs_o_q;
    assign v_sync_out = vs_o_q;

endmodule

// File: tb/tb_image_reader_pipe.sv
// Scoreboard bench for image_reader_pipe: reference model pushes expected
// address and pixel results, a monitor pops and compares each clock.
module tb_image_reader_pipe;

    localparam int L  = 2;
    localparam int CW = 4;
    localparam int IW = 320;
    localparam int IH = 240;
    localparam logic [11:0] BORDER = 12'h5A3;

    typedef struct packed {
        logic        rd;
        logic [16:0] a;
    } a_exp_t;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } p_exp_t;

    logic        clk, reset;
    logic        DE, h_sync, v_sync;
    logic [9:0]  x_pixel, y_pixel;
    logic        scale_2x, mirror_en, flip_en;
    logic [16:0] addr;
    logic        rd_en;
    logic [15:0] imgData;
    logic [3:0]  r_port, g_port, b_port;
    logic        de_out, h_sync_out, v_sync_out;

    a_exp_t aq[$];
    p_exp_t pq[$];
    int checks, failures;

    bit m_s, m_m, m_f, m_pvs;
    int m_addr;

    logic [15:0] rd_pipe [L];

    image_reader_pipe #(
        .IMG_W(IW), .IMG_H(IH), .MEM_LAT(L), .COLOR_W(CW),
        .BORDER_RGB(BORDER)
    ) dut (
        .clk(clk), .reset(reset), .DE(DE), .h_sync(h_sync),
        .v_sync(v_sync), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .scale_2x(scale_2x), .mirror_en(mirror_en), .flip_en(flip_en),
        .addr(addr), .rd_en(rd_en), .imgData(imgData),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-buffer contents; address 16100 holds magenta
    function automatic logic [15:0] data_of(int a);
        if (a == 16100) return 16'hF81F;
        return 16'((a * 40503) ^ (a >> 5));
    endfunction

    // Top CW bits of each RGB565 channel
    function automatic logic [11:0] colour(logic [15:0] d);
        int r, g, b;
        r = (d >> 11) & 31;
        g = (d >> 5) & 63;
        b = d & 31;
        return {4'(r >> (5 - CW)), 4'(g >> (6 - CW)), 4'(b >> (5 - CW))};
    endfunction

    // Synchronous-read memory with L clocks of latency
    always @(posedge clk) begin
        rd_pipe[0] <= data_of(int'(addr));
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign imgData = rd_pipe[L-1];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        p_exp_t idle;
        idle = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000};
        m_s = 1; m_m = 1; m_f = 0; m_pvs = 1; m_addr = 0;
        aq.delete();
        pq.delete();
        repeat (L + 1) pq.push_back(idle);
    endtask

    // Called at a negedge; applies inputs, records expectations, waits one clock
    task automatic drive(bit de, bit hs, bit vs, int x, int y,
                         bit s, bit m, bit f);
        int sx, sy;
        bit win;
        a_exp_t ae;
        p_exp_t pe;
        DE = de; h_sync = hs; v_sync = vs;
        x_pixel = 10'(x); y_pixel = 10'(y);
        scale_2x = s; mirror_en = m; flip_en = f;
        sx = m_s ? x / 2 : x;
        sy = m_s ? y / 2 : y;
        win = de && sx < IW && sy < IH;
        if (win)
            m_addr = (m_f ? IH - 1 - sy : sy) * IW + (m_m ? IW - 1 - sx : sx);
        ae.rd = win;
        ae.a  = 17'(m_addr);
        aq.push_back(ae);
        pe.de = de; pe.hs = hs; pe.vs = vs;
        pe.rgb = !de ? 12'h000 : (win ? colour(data_of(m_addr)) : BORDER);
        pq.push_back(pe);
        if (m_pvs && !vs) begin
            m_s = s; m_m = m; m_f = f;
        end
        m_pvs = vs;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rgb", 32'({r_port, g_port, b_port}), 32'd0);
        chk("rst_de_out", 32'(de_out), 32'd0);
        chk("rst_hs_out", 32'(h_sync_out), 32'd1);
        chk("rst_vs_out", 32'(v_sync_out), 32'd1);
    endtask

    initial begin : monitor
        a_exp_t ae;
        p_exp_t pe;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (aq.size() > 0) begin
                    ae = aq.pop_front();
                    chk("rd_en", 32'(rd_en), 32'(ae.rd));
                    chk("addr", 32'(addr), 32'(ae.a));
                end
                if (pq.size() > 0) begin
                    pe = pq.pop_front();
                    chk("de_out", 32'(de_out), 32'(pe.de));
                    chk("h_sync_out", 32'(h_sync_out), 32'(pe.hs));
                    chk("v_sync_out", 32'(v_sync_out), 32'(pe.vs));
                    chk("rgb", 32'({r_port, g_port, b_port}), 32'(pe.rgb));
                end
            end
        end
    end

    initial begin : stim
        checks = 0; failures = 0;
        reset = 1'b1;
        DE = 0; h_sync = 1; v_sync = 1;
        x_pixel = '0; y_pixel = '0;
        scale_2x = 0; mirror_en = 0; flip_en = 0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        model_init();

        // Default config 2x + mirror
        drive(1, 1, 1, 0, 0, 1, 1, 0);
        drive(1, 1, 1, 639, 479, 1, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 1, 0);
        // New frame: 1x, no mirror/flip
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 100, 50, 0, 0, 0);
        drive(1, 1, 1, 400, 50, 0, 0, 0);
        drive(1, 1, 1, 319, 239, 0, 0, 0);
        drive(1, 1, 1, 320, 100, 0, 0, 0);
        drive(1, 1, 1, 100, 240, 0, 0, 0);
        drive(1, 1, 1, 100, 50, 0, 0, 0);
        // New frame: 2x + flip; then flip_en toggled mid-frame
        drive(0, 1, 0, 0, 0, 1, 0, 1);
        drive(0, 1, 1, 0, 0, 1, 0, 1);
        drive(1, 1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 1, 639, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0, 1, 0, 0);
        // Falling v_sync with DE high still latches
        drive(1, 1, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0, 1, 0, 0);
        // Sync pulses with DE low
        for (int i = 0; i < 40; i++)
            drive(0, (i % 7) >= 2, (i % 13) >= 3, i, i, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1 chk_reset_vals();
                @(negedge clk);
                DE = 0; h_sync = 1; v_sync = 1;
                @(negedge clk);
                reset = 1'b0;
                model_init();
            end
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) != 0,
                  $urandom_range(0, 31) != 0,
                  $urandom_range(0, 700), $urandom_range(0, 520),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (L + 3) drive(0, 1, 1, 0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
